// File: rtl/lift_group_dispatch.sv
// Group dispatcher for two 8-floor cars: gathers hall calls into a pending bitmap,
// picks floors round-robin and hands each one to the nearest idle car over a valid/ack handshake.
module lift_group_dispatch #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  emergency_stop,
  input  logic                  hall_valid,
  input  logic [FLOOR_W-1:0]    hall_floor,
  output logic                  hall_ready,
  input  logic [FLOOR_W-1:0]    car0_floor,
  input  logic                  car0_idle,
  output logic [FLOOR_W-1:0]    car0_tgt,
  output logic                  car0_tgt_valid,
  input  logic                  car0_tgt_ack,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic                  car1_idle,
  output logic [FLOOR_W-1:0]    car1_tgt,
  output logic                  car1_tgt_valid,
  input  logic                  car1_tgt_ack,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  fault
);

  localparam int IDX_W = FLOOR_W + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, HALT} state_t;

  state_t                  state_reg;
  logic [NUM_FLOORS-1:0]   pending_reg;
  logic [FLOOR_W-1:0]      rr_ptr_reg;
  logic [FLOOR_W-1:0]      sel_floor_reg;
  logic                    sel_car_reg;
  logic [FLOOR_W-1:0]      car0_tgt_reg;
  logic [FLOOR_W-1:0]      car1_tgt_reg;
  logic                    car0_valid_reg;
  logic                    car1_valid_reg;
  logic                    fault_reg;
  logic [CNT_W-1:0]        timeout_cnt_reg;

  logic                    hall_accept;
  logic [NUM_FLOORS-1:0]   hall_mask;
  logic [NUM_FLOORS-1:0]   sel_mask;
  logic [NUM_FLOORS-1:0]   rot_pending;
  logic [FLOOR_W-1:0]      rot_idx [NUM_FLOORS];
  logic                    pick_found;
  logic [FLOOR_W-1:0]      pick_floor;
  logic [FLOOR_W-1:0]      dist0;
  logic [FLOOR_W-1:0]      dist1;
  logic                    pick_car1;
  logic                    any_idle;
  logic                    sel_ack;
  logic [FLOOR_W-1:0]      rr_after;

  function automatic logic [FLOOR_W-1:0] abs_diff(input logic [FLOOR_W-1:0] a,
                                                  input logic [FLOOR_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign hall_ready  = (state_reg != HALT) && !emergency_stop;
  assign hall_accept = hall_valid && hall_ready;

  // rot_pending[i] is the pending bit i floors above rr_ptr, so the lowest set bit wins
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      logic [IDX_W-1:0] idx_ext;
      assign idx_ext         = {1'b0, rr_ptr_reg} + IDX_W'(gi);
      assign rot_idx[gi]     = (idx_ext >= IDX_W'(NUM_FLOORS)) ?
                               FLOOR_W'(idx_ext - IDX_W'(NUM_FLOORS)) : idx_ext[FLOOR_W-1:0];
      assign rot_pending[gi] = pending_reg[rot_idx[gi]];
      assign hall_mask[gi]   = hall_accept && (hall_floor == FLOOR_W'(gi));
      assign sel_mask[gi]    = (sel_floor_reg == FLOOR_W'(gi));
    end
  endgenerate

  always_comb begin
    pick_found = 1'b0;
    pick_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (rot_pending[i]) begin
        pick_found = 1'b1;
        pick_floor = rot_idx[i];
      end
    end
  end

  assign dist0     = abs_diff(car0_floor, pick_floor);
  assign dist1     = abs_diff(car1_floor, pick_floor);
  assign any_idle  = car0_idle || car1_idle;
  assign pick_car1 = car1_idle && (!car0_idle || (dist1 < dist0));
  assign sel_ack   = sel_car_reg ? car1_tgt_ack : car0_tgt_ack;
  assign rr_after  = (sel_floor_reg == FLOOR_W'(NUM_FLOORS - 1)) ? '0 : sel_floor_reg + FLOOR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      pending_reg     <= '0;
      rr_ptr_reg      <= '0;
      sel_floor_reg   <= '0;
      sel_car_reg     <= 1'b0;
      car0_tgt_reg    <= '0;
      car1_tgt_reg    <= '0;
      car0_valid_reg  <= 1'b0;
      car1_valid_reg  <= 1'b0;
      fault_reg       <= 1'b0;
      timeout_cnt_reg <= '0;
    end else begin
      pending_reg <= pending_reg | hall_mask;
      if (emergency_stop) begin
        state_reg       <= HALT;
        car0_valid_reg  <= 1'b0;
        car1_valid_reg  <= 1'b0;
        timeout_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if ((|pending_reg) && any_idle) state_reg <= SELECT;
          end
          SELECT: begin
            if (pick_found && any_idle) begin
              sel_floor_reg   <= pick_floor;
              sel_car_reg     <= pick_car1;
              timeout_cnt_reg <= '0;
              state_reg       <= ISSUE;
              if (pick_car1) begin
                car1_tgt_reg   <= pick_floor;
                car1_valid_reg <= 1'b1;
              end else begin
                car0_tgt_reg   <= pick_floor;
                car0_valid_reg <= 1'b1;
              end
            end else begin
              state_reg <= IDLE;
            end
          end
          ISSUE: begin
            if (sel_ack) begin
              // a same-cycle request for the served floor counts as served
              pending_reg     <= (pending_reg | hall_mask) & ~sel_mask;
              car0_valid_reg  <= 1'b0;
              car1_valid_reg  <= 1'b0;
              rr_ptr_reg      <= rr_after;
              timeout_cnt_reg <= '0;
              state_reg       <= IDLE;
            end else if (timeout_cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
              car0_valid_reg  <= 1'b0;
              car1_valid_reg  <= 1'b0;
              fault_reg       <= 1'b1;
              rr_ptr_reg      <= rr_after;
              timeout_cnt_reg <= '0;
              state_reg       <= IDLE;
            end else begin
              timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
            end
          end
          HALT: state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign car0_tgt       = car0_tgt_reg;
  assign car1_tgt       = car1_tgt_reg;
  assign car0_tgt_valid = car0_valid_reg;
  assign car1_tgt_valid = car1_valid_reg;
  assign pending        = pending_reg;
  assign busy           = (state_reg != IDLE);
  assign fault          = fault_reg;

endmodule

// File: tb/tb_lift_group_dispatch.sv
// Self-checking bench for lift_group_dispatch: directed scenarios plus a randomized run
// scored against a transaction-level model of the pending set and dispatch choice.
module tb_lift_group_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       emergency_stop;
  logic       hall_valid;
  logic [2:0] hall_floor;
  logic       hall_ready;
  logic [2:0] car0_floor, car1_floor;
  logic       car0_idle, car1_idle;
  logic [2:0] car0_tgt, car1_tgt;
  logic       car0_tgt_valid, car1_tgt_valid;
  logic       car0_tgt_ack, car1_tgt_ack;
  logic [7:0] pending;
  logic       busy;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lift_group_dispatch dut (
    .clk(clk), .reset(reset), .emergency_stop(emergency_stop),
    .hall_valid(hall_valid), .hall_floor(hall_floor), .hall_ready(hall_ready),
    .car0_floor(car0_floor), .car0_idle(car0_idle), .car0_tgt(car0_tgt),
    .car0_tgt_valid(car0_tgt_valid), .car0_tgt_ack(car0_tgt_ack),
    .car1_floor(car1_floor), .car1_idle(car1_idle), .car1_tgt(car1_tgt),
    .car1_tgt_valid(car1_tgt_valid), .car1_tgt_ack(car1_tgt_ack),
    .pending(pending), .busy(busy), .fault(fault)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!(car0_tgt_valid || car1_tgt_valid) && n < 20) begin
      step();
      n++;
    end
    ok = car0_tgt_valid || car1_tgt_valid;
  endtask

  task automatic request(input logic [2:0] f);
    hall_valid = 1'b1;
    hall_floor = f;
    step();
    hall_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; emergency_stop = 1'b0; hall_valid = 1'b1; hall_floor = 3'd3;
    car0_idle = 1'b1; car1_idle = 1'b1; car0_floor = 3'd0; car1_floor = 3'd5;
    car0_tgt_ack = 1'b0; car1_tgt_ack = 1'b0;
    step(); step();
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h want 00", pending); end
    n_checks++; if (car0_tgt_valid !== 1'b0 || car1_tgt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b want 00", car1_tgt_valid, car0_tgt_valid); end
    n_checks++; if (car0_tgt !== 3'd0 || car1_tgt !== 3'd0) begin n_fail++; $display("FAIL reset_tgt: got %0d/%0d want 0/0", car0_tgt, car1_tgt); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_checks++; if (hall_ready !== 1'b1) begin n_fail++; $display("FAIL reset_hall_ready: got %b want 1", hall_ready); end
    hall_valid = 1'b0;
    reset = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending_after: got %h want 00", pending); end
  endtask

  task automatic test_single();
    car0_floor = 3'd0; car1_floor = 3'd5; car0_idle = 1'b1; car1_idle = 1'b1;
    request(3'd4);
    n_checks++; if (pending !== 8'h10) begin n_fail++; $display("FAIL single_pending: got %h want 10", pending); end
    step();
    n_checks++; if (busy !== 1'b1 || car1_tgt_valid !== 1'b0) begin n_fail++; $display("FAIL single_select: busy=%b valid=%b want 1/0", busy, car1_tgt_valid); end
    step();
    n_checks++; if (car1_tgt_valid !== 1'b1 || car1_tgt !== 3'd4 || car0_tgt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_issue: car1 v=%b t=%0d car0 v=%b want 1/4/0", car1_tgt_valid, car1_tgt, car0_tgt_valid); end
    step();
    n_checks++; if (car1_tgt_valid !== 1'b1 || car1_tgt !== 3'd4) begin n_fail++; $display("FAIL single_hold: v=%b t=%0d want 1/4", car1_tgt_valid, car1_tgt); end
    car1_tgt_ack = 1'b1;
    step();
    car1_tgt_ack = 1'b0;
    n_checks++; if (pending !== 8'h00 || car1_tgt_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack: pending=%h v=%b want 00/0", pending, car1_tgt_valid); end
  endtask

  task automatic test_tie_rr();
    bit ok;
    car0_idle = 1'b0; car1_idle = 1'b0; car0_floor = 3'd2; car1_floor = 3'd2;
    request(3'd1);
    request(3'd6);
    n_checks++; if (pending !== 8'h42) begin n_fail++; $display("FAIL tie_pending: got %h want 42", pending); end
    car0_idle = 1'b1; car1_idle = 1'b1;
    wait_valid(ok);
    n_checks++; if (!ok || car0_tgt_valid !== 1'b1 || car0_tgt !== 3'd6) begin
      n_fail++; $display("FAIL tie_first: ok=%b car0 v=%b t=%0d want 1/1/6", ok, car0_tgt_valid, car0_tgt); end
    car0_tgt_ack = 1'b1; step(); car0_tgt_ack = 1'b0;
    n_checks++; if (pending !== 8'h02) begin n_fail++; $display("FAIL tie_after_ack: got %h want 02", pending); end
    wait_valid(ok);
    n_checks++; if (!ok || car0_tgt_valid !== 1'b1 || car0_tgt !== 3'd1) begin
      n_fail++; $display("FAIL tie_second: ok=%b car0 v=%b t=%0d want 1/1/1", ok, car0_tgt_valid, car0_tgt); end
    car0_tgt_ack = 1'b1; step(); car0_tgt_ack = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL tie_done: got %h want 00", pending); end
  endtask

  task automatic test_duplicate();
    bit ok;
    int rises = 0;
    car0_floor = 3'd0; car1_floor = 3'd7; car0_idle = 1'b0; car1_idle = 1'b0;
    request(3'd3);
    request(3'd3);
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL dup_pending: got %h want 08", pending); end
    car0_idle = 1'b1;
    wait_valid(ok);
    n_checks++; if (!ok || car0_tgt_valid !== 1'b1 || car0_tgt !== 3'd3) begin
      n_fail++; $display("FAIL dup_issue: ok=%b v=%b t=%0d want 1/1/3", ok, car0_tgt_valid, car0_tgt); end
    car0_tgt_ack = 1'b1; hall_valid = 1'b1; hall_floor = 3'd3;
    step();
    car0_tgt_ack = 1'b0; hall_valid = 1'b0;
    n_checks++; if (pending !== 8'h00 || car0_tgt_valid !== 1'b0) begin n_fail++; $display("FAIL dup_collision: pending=%h v=%b want 00/0", pending, car0_tgt_valid); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (car0_tgt_valid || car1_tgt_valid) rises++;
    end
    n_checks++; if (rises != 0) begin n_fail++; $display("FAIL dup_single_dispatch: extra valid cycles=%0d want 0", rises); end
  endtask

  task automatic test_emergency();
    bit ok;
    car0_floor = 3'd0; car1_floor = 3'd5; car0_idle = 1'b1; car1_idle = 1'b1;
    request(3'd7);
    wait_valid(ok);
    n_checks++; if (!ok || car1_tgt_valid !== 1'b1 || car1_tgt !== 3'd7) begin
      n_fail++; $display("FAIL emg_issue: ok=%b v=%b t=%0d want 1/1/7", ok, car1_tgt_valid, car1_tgt); end
    emergency_stop = 1'b1;
    step();
    n_checks++; if (car0_tgt_valid !== 1'b0 || car1_tgt_valid !== 1'b0) begin n_fail++; $display("FAIL emg_valid_drop: got %b%b want 00", car1_tgt_valid, car0_tgt_valid); end
    n_checks++; if (hall_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL emg_ready_busy: ready=%b busy=%b want 0/1", hall_ready, busy); end
    n_checks++; if (pending[7] !== 1'b1) begin n_fail++; $display("FAIL emg_pending_kept: got %h want bit7 set", pending); end
    step();
    emergency_stop = 1'b0;
    #1;
    n_checks++; if (hall_ready !== 1'b0) begin n_fail++; $display("FAIL emg_halt_ready: got %b want 0", hall_ready); end
    step();
    n_checks++; if (hall_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL emg_exit: ready=%b busy=%b want 1/0", hall_ready, busy); end
    wait_valid(ok);
    n_checks++; if (!ok || car1_tgt_valid !== 1'b1 || car1_tgt !== 3'd7) begin
      n_fail++; $display("FAIL emg_reissue: ok=%b v=%b t=%0d want 1/1/7", ok, car1_tgt_valid, car1_tgt); end
    car1_tgt_ack = 1'b1; step(); car1_tgt_ack = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL emg_done: got %h want 00", pending); end
  endtask

  task automatic test_timeout();
    bit ok;
    int hold = 0;
    car0_floor = 3'd2; car0_idle = 1'b1; car1_idle = 1'b0;
    request(3'd2);
    wait_valid(ok);
    n_checks++; if (!ok || car0_tgt_valid !== 1'b1 || car0_tgt !== 3'd2 || fault !== 1'b0) begin
      n_fail++; $display("FAIL to_issue: ok=%b v=%b t=%0d fault=%b want 1/1/2/0", ok, car0_tgt_valid, car0_tgt, fault); end
    while (car0_tgt_valid && hold < 40) begin
      hold++;
      step();
    end
    n_checks++; if (hold != 15) begin n_fail++; $display("FAIL to_hold_cycles: got %0d want 15", hold); end
    n_checks++; if (fault !== 1'b1 || pending !== 8'h04) begin n_fail++; $display("FAIL to_fault: fault=%b pending=%h want 1/04", fault, pending); end
    wait_valid(ok);
    n_checks++; if (!ok || car0_tgt_valid !== 1'b1 || car0_tgt !== 3'd2) begin
      n_fail++; $display("FAIL to_redispatch: ok=%b v=%b t=%0d want 1/1/2", ok, car0_tgt_valid, car0_tgt); end
    car0_tgt_ack = 1'b1; step(); car0_tgt_ack = 1'b0;
    step(); step();
    n_checks++; if (fault !== 1'b1 || pending !== 8'h00) begin n_fail++; $display("FAIL to_sticky: fault=%b pending=%h want 1/00", fault, pending); end
  endtask

  task automatic test_random();
    bit [7:0] m_pend = 8'h00;
    int       m_rr = 0;
    bit       m_out = 1'b0;
    int       m_car = 0, m_floor = 0, age = 0;
    reset = 1'b0; hall_valid = 1'b0; car0_tgt_ack = 1'b0; car1_tgt_ack = 1'b0;
    step();
    reset = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit [7:0] pend_b;
      bit       was_out, acked;
      int       exp_floor, exp_car, d0, d1;
      hall_valid = ($urandom_range(0, 2) == 0);
      hall_floor = 3'($urandom_range(0, 7));
      car0_floor = 3'($urandom_range(0, 7));
      car1_floor = 3'($urandom_range(0, 7));
      car0_idle  = ($urandom_range(0, 3) != 0);
      car1_idle  = ($urandom_range(0, 3) != 0);
      car0_tgt_ack = ($urandom_range(0, 3) == 0);
      car1_tgt_ack = ($urandom_range(0, 3) == 0);
      if (m_out) begin
        bit give = ($urandom_range(0, 2) == 0) || (age >= 8);
        if (m_car == 0) car0_tgt_ack = give; else car1_tgt_ack = give;
      end
      pend_b  = m_pend;
      was_out = m_out;
      exp_floor = -1;
      for (int off = 0; off < 8; off++) begin
        int f = (m_rr + off) % 8;
        if (exp_floor < 0 && pend_b[f]) exp_floor = f;
      end
      d0 = int'(car0_floor) - exp_floor; if (d0 < 0) d0 = -d0;
      d1 = int'(car1_floor) - exp_floor; if (d1 < 0) d1 = -d1;
      if (car0_idle && car1_idle) exp_car = (d1 < d0) ? 1 : 0;
      else if (car0_idle) exp_car = 0;
      else if (car1_idle) exp_car = 1;
      else exp_car = -1;
      acked = was_out && ((m_car == 0) ? car0_tgt_ack : car1_tgt_ack);
      step();
      if (hall_valid) m_pend[hall_floor] = 1'b1;
      if (acked) begin
        m_pend[m_floor] = 1'b0;
        m_rr  = (m_floor + 1) % 8;
        m_out = 1'b0;
      end
      n_checks++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending cyc=%0d: got %h want %h", cyc, pending, m_pend); end
      n_checks++; if (hall_ready !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_fault cyc=%0d: ready=%b fault=%b want 1/0", cyc, hall_ready, fault); end
      n_checks++; if (car0_tgt_valid && car1_tgt_valid) begin n_fail++; $display("FAIL rnd_both_valid cyc=%0d: got 11 want at most one", cyc); end
      if (was_out && !acked) begin
        age++;
        n_checks++;
        if ((m_car == 0 && (car0_tgt_valid !== 1'b1 || int'(car0_tgt) != m_floor)) ||
            (m_car == 1 && (car1_tgt_valid !== 1'b1 || int'(car1_tgt) != m_floor))) begin
          n_fail++; $display("FAIL rnd_hold cyc=%0d: car%0d v0=%b t0=%0d v1=%b t1=%0d want floor %0d", cyc, m_car, car0_tgt_valid, car0_tgt, car1_tgt_valid, car1_tgt, m_floor);
        end
      end else if (was_out && acked) begin
        n_checks++; if (car0_tgt_valid || car1_tgt_valid) begin n_fail++; $display("FAIL rnd_ack_drop cyc=%0d: got %b%b want 00", cyc, car1_tgt_valid, car0_tgt_valid); end
      end else if (car0_tgt_valid || car1_tgt_valid) begin
        int got_car   = car1_tgt_valid ? 1 : 0;
        int got_floor = car1_tgt_valid ? int'(car1_tgt) : int'(car0_tgt);
        n_checks++;
        if (got_car != exp_car || got_floor != exp_floor) begin
          n_fail++; $display("FAIL rnd_dispatch cyc=%0d: got car%0d floor %0d want car%0d floor %0d", cyc, got_car, got_floor, exp_car, exp_floor);
        end
        m_out = 1'b1; m_car = exp_car; m_floor = exp_floor; age = 0;
      end
    end
    car0_tgt_ack = 1'b0; car1_tgt_ack = 1'b0; hall_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; emergency_stop = 1'b0; hall_valid = 1'b0; hall_floor = 3'd0;
    car0_floor = 3'd0; car1_floor = 3'd0; car0_idle = 1'b0; car1_idle = 1'b0;
    car0_tgt_ack = 1'b0; car1_tgt_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_tie_rr();
    test_duplicate();
    test_emergency();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lift_group_dispatch.md
Name: lift_group_dispatch

Overview:
- Group dispatcher sharing hall calls between two 8-floor elevator cars (two Lift8 instances).
- Collects floor requests into a pending bitmap and picks one pending floor at a time, round-robin.
- Assigns the floor to the nearest idle car with a valid/ack handshake.
- Freezes dispatch on emergency stop and flags cars that never acknowledge.

Parameters:
- NUM_FLOORS, 8, number of floors; pending bitmap width.
- FLOOR_W, 3, floor index width.
- ACK_TIMEOUT, 15, max cycles ISSUE waits for ack before abort.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- emergency_stop  input  1  level; freezes dispatch while high.
- hall_valid  input  1  hall request strobe.
- hall_floor  input  FLOOR_W  requested floor.
- hall_ready  output  1  request accepted when hall_valid && hall_ready.
- car0_floor  input  FLOOR_W  car 0 current floor.
- car0_idle  input  1  car 0 can take a new target.
- car0_tgt  output  FLOOR_W  target floor for car 0.
- car0_tgt_valid  output  1  car 0 target valid.
- car0_tgt_ack  input  1  car 0 accepts target.
- car1_floor, car1_idle, car1_tgt, car1_tgt_valid, car1_tgt_ack  same as car 0, for car 1.
- pending  output  NUM_FLOORS  outstanding request bitmap.
- busy  output  1  FSM not in IDLE.
- fault  output  1  sticky ack-timeout flag.

Behaviour:
- Reset (reset==0 at clk edge):
  - pending=0, rr_ptr=0, state=IDLE.
  - car0_tgt=car1_tgt=0, both tgt_valid=0, fault=0, busy=0, timeout counter=0.
- hall_ready = (state!=HALT) && !emergency_stop. It is combinational.
- Accepted request sets pending[hall_floor] at that edge. A request for an already-pending floor merges (no effect).
- FSM states: IDLE, SELECT, ISSUE, HALT.
- IDLE: if pending!=0 and (car0_idle || car1_idle), go to SELECT.
- SELECT: registers the dispatch choice, then goes to ISSUE.
  - sel_floor = first set pending bit searching upward from rr_ptr, wrapping 7->0.
  - sel_car = the idle car with smaller |carN_floor - sel_floor|. Tie goes to car 0.
  - If no car is idle at this point, return to IDLE.
- ISSUE: carN_tgt=sel_floor and carN_tgt_valid=1, both registered and held stable until ack. The other car's valid stays 0.
- On carN_tgt_ack while valid:
  - Drop valid at that edge.
  - Clear pending[sel_floor].
  - rr_ptr = sel_floor+1 mod 8.
  - Go to IDLE.
- Ack on the non-selected car, or ack while valid=0: ignored.
- Ack arriving in the same cycle as a new hall request for sel_floor: the clear wins; the request is treated as served.
- Timeout: the counter increments each ISSUE cycle without ack. On reaching ACK_TIMEOUT:
  - Drop valid, set fault=1 (sticky until reset).
  - Leave pending unchanged, set rr_ptr = sel_floor+1, return to IDLE.
- Latency: a hall request sampled at edge k gives tgt_valid high after edge k+2, provided a car is idle and there is no contention.
- busy=1 in SELECT, ISSUE and HALT.
- emergency_stop=1 at any edge, from any state:
  - Go to HALT and drop both tgt_valid at that edge.
  - Clear the timeout counter. pending is preserved.
- HALT: exit to IDLE at the first edge with emergency_stop=0.
- A request for a car's own current floor is dispatched normally (car opens door).
- A reset mid-ISSUE clears everything immediately, regardless of ack.

Test Plan:
- Reset sequence: reset=0 for 2 cycles -> pending=00, both valid=0, fault=0, hall_ready=1; after release, busy=0.
- Single request: car0_floor=0, car1_floor=5, both idle, hall_floor=4 at edge k -> pending=10h after k; car1_tgt=4, car1_tgt_valid=1 after k+2; ack at k+4 -> pending=00, valid=0, rr_ptr=5.
- Tie and round-robin: both cars at floor 2, pending floors 1 and 6, rr_ptr=5 -> floor 6 dispatched to car0 first; after ack, floor 1 dispatched next.
- Duplicate and collision: request floor 3 twice -> pending=08h with a single dispatch; a floor 3 request in the same cycle as the floor-3 ack -> pending bit 3=0.
- Emergency: during ISSUE to floor 7, emergency_stop=1 for 20 ns -> valid drops at next edge, hall_ready=0, pending bit 7 kept; after release, floor 7 is reissued.
- Timeout: no ack for 15 ISSUE cycles -> valid=0, fault=1 (remains 1), pending bit retained and redispatched.
